mem_arbiter: RTL

Two-port to one-port memory arbiter that shares a single unified instruction/data memory between the fetch stage and the memory stage of the MIPS core. It sequences every access through a fixed request/acknowledge handshake toward memory. The data port is driven by the decoder's MemRead/MemWrite and has fixed priority over instruction fetch, because the memory-stage instruction is older. The arbiter registers all outputs and returns one-cycle ready pulses that the pipeline uses as stall release.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to one-port memory arbiter with fixed data priority and registered outputs.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that completes with zero data and sets sticky err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_D = 3'd1;
  localparam logic [2:0] S_BUSY_I = 3'd2;
  localparam logic [2:0] S_RESP_D = 3'd3;
  localparam logic [2:0] S_RESP_I = 3'd4;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_arbiter: TIMEOUT must be in 2..255");
  end

  logic [2:0] state;
  logic       in_busy;
  logic       timeout_hit;

  assign in_busy = (state == S_BUSY_D) || (state == S_BUSY_I);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tcnt;

  // A real ack in the final wait cycle beats the watchdog.
  assign timeout_hit = (tcnt == 8'(TIMEOUT - 1)) && !mem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (!in_busy)
        tcnt <= '0;
      else if (!mem_ack)
        tcnt <= tcnt + 8'd1;
      if (in_busy && timeout_hit)
        err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dm_read || dm_write) begin
            state     <= S_BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            busy      <= 1'b1;
          end else if (if_req) begin
            state     <= S_BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            busy      <= 1'b1;
          end
        end
        S_BUSY_D: begin
          if (mem_ack || timeout_hit) begin
            state    <= S_RESP_D;
            mem_req  <= 1'b0;
            dm_ready <= 1'b1;
            // Stores and timed-out loads both return zero.
            dm_rdata <= (mem_we || timeout_hit) ? '0 : mem_rdata;
          end
        end
        S_BUSY_I: begin
          if (mem_ack || timeout_hit) begin
            state    <= S_RESP_I;
            mem_req  <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= timeout_hit ? '0 : mem_rdata;
          end
        end
        S_RESP_D, S_RESP_I: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
